// File: rtl/sort4_ctrl.sv
// sort4_ctrl: sequential 4-element bubble sorter. One comparison per clock
// through a single shared unsigned comparator, with early exit once a pass
// completes without swapping. Equal elements are never swapped (stable).
//
// Handshake: start is only looked at in IDLE; the edge that sees start=1
// captures din0..din3 and begins sorting. busy is high for every comparison
// cycle, done pulses for one cycle when the result in dout0..dout3 is final,
// and the result holds until the next accepted start. start is ignored
// while busy or done.

// Shared WIDTH-bit unsigned magnitude comparator (the 8-bit comparator when
// WIDTH=8). Exactly one of lt/gt/eq is high.
module sort4_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  // Pure combinational magnitude compare
  always_comb begin
    lt = (a < b);
    gt = (a > b);
    eq = (a == b);
  end

endmodule

module sort4_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             busy,
  output logic             done,
  output logic [2:0]       swap_cnt,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] r0_q, r0_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [WIDTH-1:0] r3_q, r3_d;
  logic [2:0]       swap_cnt_q, swap_cnt_d;
  logic [1:0]       pass_q, pass_d;
  logic [1:0]       j_q, j_d;
  // Set once any swap has happened in the current pass
  logic             pass_swap_q, pass_swap_d;

  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_lt;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             pass_last;
  logic             pass_any_swap;

  // Operand mux: present r[j] and r[j+1] to the shared comparator
  always_comb begin
    cmp_a = r0_q;
    cmp_b = r1_q;
    case (j_q)
      2'd1: begin
        cmp_a = r1_q;
        cmp_b = r2_q;
      end
      2'd2: begin
        cmp_a = r2_q;
        cmp_b = r3_q;
      end
      default: begin
        cmp_a = r0_q;
        cmp_b = r1_q;
      end
    endcase
  end

  sort4_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .lt (cmp_lt),
    .gt (cmp_gt),
    .eq (cmp_eq)
  );

  // Pass bookkeeping: last index of pass p is 2-p; the pass swap flag
  // includes a swap made on this very comparison.
  always_comb begin
    pass_last     = (j_q == (2'd2 - pass_q));
    pass_any_swap = pass_swap_q | cmp_gt;
  end

  // Next-state and datapath update; lt and eq both mean "leave in place"
  always_comb begin
    state_d     = state_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    swap_cnt_d  = swap_cnt_q;
    pass_d      = pass_q;
    j_d         = j_q;
    pass_swap_d = pass_swap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          r0_d        = din0;
          r1_d        = din1;
          r2_d        = din2;
          r3_d        = din3;
          swap_cnt_d  = 3'd0;
          pass_d      = 2'd0;
          j_d         = 2'd0;
          pass_swap_d = 1'b0;
          state_d     = S_CMP;
        end
      end
      S_CMP: begin
        if (cmp_gt) begin
          swap_cnt_d = swap_cnt_q + 3'd1;
          case (j_q)
            2'd1: begin
              r1_d = r2_q;
              r2_d = r1_q;
            end
            2'd2: begin
              r2_d = r3_q;
              r3_d = r2_q;
            end
            default: begin
              r0_d = r1_q;
              r1_d = r0_q;
            end
          endcase
        end
        if (pass_last) begin
          if (!pass_any_swap || (pass_q == 2'd2)) begin
            state_d = S_DONE;
          end else begin
            pass_d      = pass_q + 2'd1;
            j_d         = 2'd0;
            pass_swap_d = 1'b0;
          end
        end else begin
          j_d         = j_q + 2'd1;
          pass_swap_d = pass_any_swap;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      r0_q        <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      swap_cnt_q  <= 3'd0;
      pass_q      <= 2'd0;
      j_q         <= 2'd0;
      pass_swap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      swap_cnt_q  <= swap_cnt_d;
      pass_q      <= pass_d;
      j_q         <= j_d;
      pass_swap_q <= pass_swap_d;
    end
  end

  // Outputs decode directly from registered state, so reset clears them at once
  always_comb begin
    dout0     = r0_q;
    dout1     = r1_q;
    dout2     = r2_q;
    dout3     = r3_q;
    swap_cnt  = swap_cnt_q;
    busy      = (state_q == S_CMP);
    done      = (state_q == S_DONE);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Directed bench for sort4_ctrl. Edges are counted from the start-accepting
// edge (edge 0); done must be the value seen by edge k+1, i.e. it is high in
// the cycle that follows the k-th comparison edge.
module tb_sort4_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] din0, din1, din2, din3;
  logic [7:0] dout0, dout1, dout2, dout3;
  logic       busy;
  logic       done;
  logic [2:0] swap_cnt;
  logic [1:0] state_dbg;

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  sort4_ctrl #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din0      (din0),
    .din1      (din1),
    .din2      (din2),
    .din3      (din3),
    .dout0     (dout0),
    .dout1     (dout1),
    .dout2     (dout2),
    .dout3     (dout3),
    .busy      (busy),
    .done      (done),
    .swap_cnt  (swap_cnt),
    .state_dbg (state_dbg)
  );

  // Clock and global watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_din(input logic [7:0] a, b, c, d);
    din0 = a;
    din1 = b;
    din2 = c;
    din3 = d;
  endtask

  // One full sort; optional poke pulses start with new operands mid-sort
  task automatic run_sort(input string tag,
                          input logic [7:0] a, b, c, d,
                          input logic [7:0] ea, eb, ec, ed,
                          input logic [2:0] esw, input int ek, input bit poke);
    int got;
    logic [31:0] exp;
    exp_q.push_back({ed, ec, eb, ea});
    @(negedge clk);
    drive_din(a, b, c, d);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    got = 0;
    for (int n = 1; n <= 12; n++) begin
      if (poke && n == 2) begin
        start = 1'b1;
        drive_din(8'd1, 8'd2, 8'd3, 8'd4);
      end
      if (poke && n == 3) start = 1'b0;
      if (done) begin
        got = n;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done_edge"}, got, ek + 1);
    exp = exp_q.pop_front();
    check({tag, "_dout"}, {dout3, dout2, dout1, dout0}, exp);
    check({tag, "_swap_cnt"}, {29'd0, swap_cnt}, {29'd0, esw});
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse_len"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {30'd0, state_dbg}, 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_hold"}, {dout3, dout2, dout1, dout0}, exp);
    check({tag, "_hold_swap"}, {29'd0, swap_cnt}, {29'd0, esw});
  endtask

  initial begin
    int seen;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    drive_din(8'd0, 8'd0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    check("rst_dout", {dout3, dout2, dout1, dout0}, 32'd0);
    check("rst_flags", {27'd0, swap_cnt, busy, done}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rst = 1'b0;

    // Idle with start low holds everything
    drive_din(8'd9, 8'd8, 8'd7, 8'd6);
    repeat (2) @(negedge clk);
    check("idle_hold", {dout3, dout2, dout1, dout0}, 32'd0);

    run_sort("sorted",  8'd10,  8'd20,  8'd30,  8'd40,
                        8'd10,  8'd20,  8'd30,  8'd40, 3'd0, 3, 1'b0);
    run_sort("reverse", 8'd100, 8'd70,  8'd50,  8'd30,
                        8'd30,  8'd50,  8'd70,  8'd100, 3'd6, 6, 1'b0);
    run_sort("mixed",   8'd30,  8'd10,  8'd20,  8'd40,
                        8'd10,  8'd20,  8'd30,  8'd40, 3'd2, 5, 1'b0);
    run_sort("equal",   8'd100, 8'd100, 8'd50,  8'd50,
                        8'd50,  8'd50,  8'd100, 8'd100, 3'd4, 6, 1'b0);
    run_sort("ignore",  8'd40,  8'd30,  8'd20,  8'd10,
                        8'd10,  8'd20,  8'd30,  8'd40, 3'd6, 6, 1'b1);

    // Start held high through DONE: re-accepted after one IDLE cycle
    @(negedge clk);
    drive_din(8'd5, 8'd6, 8'd7, 8'd8);
    start = 1'b1;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("b2b_first_done", seen, 1);
    drive_din(8'd4, 8'd3, 8'd2, 8'd1);
    @(negedge clk);
    check("b2b_idle_gap", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_reaccept", {31'd0, busy}, 32'd1);
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("b2b_second_done", seen, 1);
    check("b2b_dout", {dout3, dout2, dout1, dout0}, {8'd4, 8'd3, 8'd2, 8'd1});
    check("b2b_swap_cnt", {29'd0, swap_cnt}, 32'd6);
    repeat (2) @(negedge clk);

    // Reset during the second CMP cycle
    drive_din(8'd100, 8'd70, 8'd50, 8'd30);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("mid_first_cmp", {dout3, dout2, dout1, dout0}, {8'd30, 8'd50, 8'd100, 8'd70});
    check("mid_busy", {31'd0, busy}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_dout", {dout3, dout2, dout1, dout0}, 32'd0);
    check("mid_rst_flags", {27'd0, swap_cnt, busy, done}, 32'd0);
    check("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("mid_rst_no_done", seen, 0);
    check("mid_rst_hold", {dout3, dout2, dout1, dout0}, 32'd0);
    run_sort("post_rst", 8'd30, 8'd10, 8'd20, 8'd40,
                         8'd10, 8'd20, 8'd30, 8'd40, 3'd2, 5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
